// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counter: FSM encoding, BCD widths and
// the packed MM:SS time record.
package stopwatch_pkg;

   localparam int BCD_W      = 4;
   localparam int DIGIT_MAX9 = 9;
   localparam int DIGIT_MAX5 = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_e;

   typedef struct packed {
      logic [BCD_W-1:0] mt;
      logic [BCD_W-1:0] mo;
      logic [BCD_W-1:0] st;
      logic [BCD_W-1:0] so;
   } sw_time_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counting 0..MAX; carry is combinational so a cascade of
// digits all step on the same clock edge.
module bcd_digit_cnt
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX = 9
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] q,
   output logic             carry
);

   localparam logic [BCD_W-1:0] MAX_Q = BCD_W'(MAX);

   always_ff @(posedge clock) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == MAX_Q) ? '0 : q + 1'b1;
      end
   end

   assign carry = inc && (q == MAX_Q);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch driven by the divided tick wave, treated as data in the
// system clock domain. Start/stop, lap freeze and clear via button pulses.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICKS_PER_INC = 1,
   parameter int unsigned MIN_TENS_MAX  = 5
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             start_stop,
   input  logic             lap,
   input  logic             clear,
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] min_tens,
   output logic             running,
   output logic             frozen,
   output logic             wrap,
   output sw_state_e        fsm_state
);

   localparam logic [7:0] PRESC_TERM = 8'(TICKS_PER_INC - 1);

   sw_state_e  state, state_next;
   logic       tick_s1, tick_s2, tick_s3;
   logic       ss_q, lap_q, clr_q;
   logic       tick_pulse, ss_p, lap_p, clr_p;
   logic       count_en, zero, step;
   logic [7:0] presc;
   sw_time_t   live, snap;
   logic       so_carry, st_carry, mo_carry, mt_carry;

   // Flops reset to 1 so a level held high through reset is not a press/tick.
   always_ff @(posedge clock) begin
      if (rst) begin
         tick_s1 <= 1'b1;
         tick_s2 <= 1'b1;
         tick_s3 <= 1'b1;
         ss_q    <= 1'b1;
         lap_q   <= 1'b1;
         clr_q   <= 1'b1;
      end else begin
         tick_s1 <= tick_in;
         tick_s2 <= tick_s1;
         tick_s3 <= tick_s2;
         ss_q    <= start_stop;
         lap_q   <= lap;
         clr_q   <= clear;
      end
   end

   assign tick_pulse = tick_s2 & ~tick_s3;
   assign ss_p       = start_stop & ~ss_q;
   assign lap_p      = lap & ~lap_q;
   assign clr_p      = clear & ~clr_q;

   always_ff @(posedge clock) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (ss_p) state_next = ST_RUN;
         ST_RUN:   if (ss_p) state_next = ST_PAUSE;
         ST_PAUSE: begin
            if (clr_p)     state_next = ST_IDLE;
            else if (ss_p) state_next = ST_RUN;
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      running  = (state == ST_RUN);
      count_en = (state == ST_RUN) && tick_pulse;
      zero     = (state_next == ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (rst || zero) begin
         presc <= '0;
      end else if (count_en) begin
         presc <= (presc == PRESC_TERM) ? 8'd0 : presc + 8'd1;
      end
   end

   assign step = count_en && (presc == PRESC_TERM);

   bcd_digit_cnt #(.MAX(DIGIT_MAX9)) u_so (
      .clock(clock), .rst(rst), .clr(zero), .inc(step),
      .q(live.so), .carry(so_carry));
   bcd_digit_cnt #(.MAX(DIGIT_MAX5)) u_st (
      .clock(clock), .rst(rst), .clr(zero), .inc(so_carry),
      .q(live.st), .carry(st_carry));
   bcd_digit_cnt #(.MAX(DIGIT_MAX9)) u_mo (
      .clock(clock), .rst(rst), .clr(zero), .inc(st_carry),
      .q(live.mo), .carry(mo_carry));
   bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_mt (
      .clock(clock), .rst(rst), .clr(zero), .inc(mo_carry),
      .q(live.mt), .carry(mt_carry));

   // Snapshot takes the current (pre-increment) live value on a lap press.
   always_ff @(posedge clock) begin
      if (rst || zero) begin
         frozen <= 1'b0;
         snap   <= '0;
      end else if (lap_p) begin
         case (state)
            ST_RUN: begin
               if (!frozen) begin
                  snap   <= live;
                  frozen <= 1'b1;
               end else begin
                  frozen <= 1'b0;
               end
            end
            ST_PAUSE: frozen <= 1'b0;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rst) wrap <= 1'b0;
      else     wrap <= mt_carry;
   end

   assign sec_ones  = frozen ? snap.so : live.so;
   assign sec_tens  = frozen ? snap.st : live.st;
   assign min_ones  = frozen ? snap.mo : live.mo;
   assign min_tens  = frozen ? snap.mt : live.mt;
   assign fsm_state = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: one instance at one tick per second,
// a second instance with four ticks per second for the prescaler.
module tb_stopwatch_counter;
   import stopwatch_pkg::*;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       tick_in = 1'b1, start_stop = 1'b1, lap = 1'b0, clear = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, frozen, wrap;
   sw_state_e  fsm_state;

   logic       tick4 = 1'b0, ss4 = 1'b0, lap4 = 1'b0, clr4 = 1'b0;
   logic [3:0] so4, st4, mo4, mt4;
   logic       running4, frozen4, wrap4;
   sw_state_e  fsm_state4;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   stopwatch_counter #(.TICKS_PER_INC(1), .MIN_TENS_MAX(5)) u_dut (
      .clock(clock), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
      .lap(lap), .clear(clear), .sec_ones(sec_ones), .sec_tens(sec_tens),
      .min_ones(min_ones), .min_tens(min_tens), .running(running),
      .frozen(frozen), .wrap(wrap), .fsm_state(fsm_state));

   stopwatch_counter #(.TICKS_PER_INC(4), .MIN_TENS_MAX(5)) u_dut4 (
      .clock(clock), .rst(rst), .tick_in(tick4), .start_stop(ss4),
      .lap(lap4), .clear(clr4), .sec_ones(so4), .sec_tens(st4),
      .min_ones(mo4), .min_tens(mt4), .running(running4),
      .frozen(frozen4), .wrap(wrap4), .fsm_state(fsm_state4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] disp();
      return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   function automatic logic [31:0] disp4();
      return {16'h0, mt4, mo4, st4, so4};
   endfunction

   // Full tick: high two cycles, low two cycles; count settles before return.
   task automatic tick();
      @(negedge clock) tick_in = 1'b1;
      repeat (2) @(negedge clock);
      tick_in = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press(input logic do_ss, input logic do_lap, input logic do_clr);
      @(negedge clock);
      start_stop = do_ss;
      lap        = do_lap;
      clear      = do_clr;
      @(negedge clock);
      start_stop = 1'b0;
      lap        = 1'b0;
      clear      = 1'b0;
      @(negedge clock);
   endtask

   task automatic tick_b();
      @(negedge clock) tick4 = 1'b1;
      repeat (2) @(negedge clock);
      tick4 = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic press_b();
      @(negedge clock) ss4 = 1'b1;
      @(negedge clock) ss4 = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      int wrap_cnt;

      // 1: reset with tick_in and start_stop held high
      repeat (3) @(negedge clock);
      chk("rst_disp", disp(), 32'h0000);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_frozen", 32'(frozen), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clock);
      chk("held_state", 32'(fsm_state), 32'(ST_IDLE));
      chk("held_disp", disp(), 32'h0000);
      start_stop = 1'b0;
      tick_in    = 1'b0;
      repeat (3) @(negedge clock);
      chk("low_state", 32'(fsm_state), 32'(ST_IDLE));
      press(1'b1, 1'b0, 1'b0);
      chk("start_running", 32'(running), 32'd1);
      chk("start_state", 32'(fsm_state), 32'(ST_RUN));
      chk("start_disp", disp(), 32'h0000);

      // 2: 61 ticks -> 01:01, then pause holds
      ticks(61);
      chk("t61_disp", disp(), 32'h0101);
      chk("t61_running", 32'(running), 32'd1);
      press(1'b1, 1'b0, 1'b0);
      chk("pause_state", 32'(fsm_state), 32'(ST_PAUSE));
      chk("pause_running", 32'(running), 32'd0);
      ticks(3);
      chk("pause_hold", disp(), 32'h0101);
      press(1'b0, 1'b0, 1'b1);
      chk("clear_pause_state", 32'(fsm_state), 32'(ST_IDLE));
      chk("clear_pause_disp", disp(), 32'h0000);

      // 5: start_stop+clear in PAUSE -> clear wins; clear in RUN ignored
      press(1'b1, 1'b0, 1'b0);
      ticks(7);
      chk("t7_disp", disp(), 32'h0007);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b1);
      chk("ssclr_state", 32'(fsm_state), 32'(ST_IDLE));
      chk("ssclr_disp", disp(), 32'h0000);
      chk("ssclr_running", 32'(running), 32'd0);
      press(1'b1, 1'b0, 1'b0);
      ticks(7);
      press(1'b0, 1'b0, 1'b1);
      chk("clr_run_disp", disp(), 32'h0007);
      chk("clr_run_running", 32'(running), 32'd1);

      // 4: lap freeze at 00:10, live keeps counting
      ticks(3);
      chk("t10_disp", disp(), 32'h0010);
      press(1'b0, 1'b1, 1'b0);
      chk("lap_frozen", 32'(frozen), 32'd1);
      ticks(5);
      chk("lap_hold_disp", disp(), 32'h0010);
      press(1'b0, 1'b1, 1'b0);
      chk("unlap_frozen", 32'(frozen), 32'd0);
      chk("unlap_disp", disp(), 32'h0015);

      // 3: run up to 59:59, then one tick wraps with a single-cycle pulse
      ticks(3599 - 15);
      chk("t5959_disp", disp(), 32'h5959);
      wrap_cnt = 0;
      @(negedge clock) tick_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (i == 1) tick_in = 1'b0;
         if (wrap) wrap_cnt++;
         if (i == 2) chk("wrap_at_rollover", 32'(wrap), 32'd1);
      end
      chk("wrap_pulses", 32'(wrap_cnt), 32'd1);
      chk("wrap_disp", disp(), 32'h0000);
      chk("wrap_running", 32'(running), 32'd1);
      tick();
      chk("after_wrap_disp", disp(), 32'h0001);

      // 6: TICKS_PER_INC=4 prescaler holds across pause
      chk("b_idle", 32'(fsm_state4), 32'(ST_IDLE));
      press_b();
      chk("b_running", 32'(running4), 32'd1);
      for (int i = 0; i < 7; i++) tick_b();
      chk("b_t7_disp", disp4(), 32'h0001);
      press_b();
      chk("b_pause", 32'(fsm_state4), 32'(ST_PAUSE));
      press_b();
      tick_b();
      chk("b_resume_disp", disp4(), 32'h0002);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
